// File: rtl/conv_3x3_stream_feeder_pkg.sv
// Shared definitions for the 3x3 conv stream feeder.
//   - KernelSize   : weights per (co, ci) pair, fixed at 9
//   - DrainLast    : index of the DRAIN cycle that pulses done
//   - feeder_state_e : FSM encoding (idle, weights, pixels, drain)
//   - clog2_min1 / image_size : width and size derivations used by the top
package conv_3x3_stream_feeder_pkg;

    localparam int unsigned KernelSize = 9;
    localparam int unsigned KCntW      = 4;
    // Two cycles for in-flight reads to emit, done on the third DRAIN cycle.
    localparam logic [1:0]  DrainLast  = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StWeights,
        StPixels,
        StDrain
    } feeder_state_e;

    // Counters and addresses need at least one bit even for a range of one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned image_size(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/conv_3x3_stream_feeder_outreg.sv
// Output stage of one feeder stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rd_en_i       : RAM read strobe issued this cycle
//   rd_data_i     : RAM read data, valid the cycle after rd_en_i
//   valid_o       : rd_en_i delayed by two cycles
//   data_o        : rd_data_i registered once; holds while valid_o is low
module conv_3x3_stream_feeder_outreg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  rd_en_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rd_en_q <= rd_en_i;
            valid_q <= rd_en_q;
            // rd_en_q marks the cycle in which the RAM presents the word.
            if (rd_en_q) begin
                data_q <= rd_data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/conv_3x3_stream_feeder.sv
// Reads kernel weights and feature-map planes from layer RAMs and emits them as the
// weight and pixel streams of the 3x3 conv top: per (co, ci) pair, 9 weights then
// the full plane in raster order.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   start_i             : one-cycle request to stream a whole layer (ignored while busy)
//   hold_i              : pause; no new RAM reads while high
//   fm_rd_*             : feature-map RAM port, addr = ci*IMAGE_SIZE + pix
//   wt_rd_*             : weight RAM port, addr = (co*CHANNEL_NUM_IN + ci)*9 + k
//   pxl_o / valid_o     : pixel stream
//   weight_o / valid_weight_o : weight stream
//   busy_o, done_o      : layer in progress, one-cycle completion pulse
module conv_3x3_stream_feeder
    import conv_3x3_stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IMAGE_WIDTH     = 16,
    parameter int unsigned IMAGE_HEIGHT    = 16,
    parameter int unsigned CHANNEL_NUM_IN  = 256,
    parameter int unsigned CHANNEL_NUM_OUT = 256,
    localparam int unsigned ImageSize = image_size(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int unsigned FmAw = clog2_min1(CHANNEL_NUM_IN * ImageSize),
    localparam int unsigned WtAw = clog2_min1(CHANNEL_NUM_OUT * CHANNEL_NUM_IN * KernelSize)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic                  fm_rd_en_o,
    output logic [FmAw-1:0]       fm_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] fm_rd_data_i,
    output logic                  wt_rd_en_o,
    output logic [WtAw-1:0]       wt_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] wt_rd_data_i,
    output logic [DATA_WIDTH-1:0] pxl_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] weight_o,
    output logic                  valid_weight_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned PixW = clog2_min1(ImageSize);
    localparam int unsigned CiW  = clog2_min1(CHANNEL_NUM_IN);
    localparam int unsigned CoW  = clog2_min1(CHANNEL_NUM_OUT);

    localparam logic [KCntW-1:0] KLast   = KCntW'(KernelSize - 1);
    localparam logic [PixW-1:0]  PixLast = PixW'(ImageSize - 1);
    localparam logic [CiW-1:0]   CiLast  = CiW'(CHANNEL_NUM_IN - 1);
    localparam logic [CoW-1:0]   CoLast  = CoW'(CHANNEL_NUM_OUT - 1);

    feeder_state_e    state_q, state_d;
    logic [KCntW-1:0] k_q, k_d;
    logic [PixW-1:0]  pix_q, pix_d;
    logic [CiW-1:0]   ci_q, ci_d;
    logic [CoW-1:0]   co_q, co_d;
    logic [1:0]       drain_q, drain_d;

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            k_q     <= '0;
            pix_q   <= '0;
            ci_q    <= '0;
            co_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pix_q   <= pix_d;
            ci_q    <= ci_d;
            co_q    <= co_d;
            drain_q <= drain_d;
        end
    end

    // Next state; hold freezes the read-issuing states only.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pix_d   = pix_q;
        ci_d    = ci_q;
        co_d    = co_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWeights;
                    k_d     = '0;
                    pix_d   = '0;
                    ci_d    = '0;
                    co_d    = '0;
                    drain_d = '0;
                end
            end
            StWeights: begin
                if (!hold_i) begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        state_d = StPixels;
                    end else begin
                        k_d = k_q + KCntW'(1);
                    end
                end
            end
            StPixels: begin
                if (!hold_i) begin
                    if (pix_q == PixLast) begin
                        pix_d   = '0;
                        state_d = StWeights;
                        if (ci_q != CiLast) begin
                            ci_d = ci_q + CiW'(1);
                        end else begin
                            ci_d = '0;
                            if (co_q != CoLast) begin
                                co_d = co_q + CoW'(1);
                            end else begin
                                co_d    = '0;
                                state_d = StDrain;
                            end
                        end
                    end else begin
                        pix_d = pix_q + PixW'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    drain_d = '0;
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and counters.
    always_comb begin
        wt_rd_en_o   = (state_q == StWeights) && !hold_i;
        fm_rd_en_o   = (state_q == StPixels) && !hold_i;
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDrain) && (drain_q == DrainLast);
        fm_rd_addr_o = FmAw'(ci_q) * FmAw'(ImageSize) + FmAw'(pix_q);
        wt_rd_addr_o = (WtAw'(co_q) * WtAw'(CHANNEL_NUM_IN) + WtAw'(ci_q)) * WtAw'(KernelSize)
                       + WtAw'(k_q);
    end

    conv_3x3_stream_feeder_outreg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wt_outreg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_en_i   (wt_rd_en_o),
        .rd_data_i (wt_rd_data_i),
        .valid_o   (valid_weight_o),
        .data_o    (weight_o)
    );

    conv_3x3_stream_feeder_outreg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fm_outreg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_en_i   (fm_rd_en_o),
        .rd_data_i (fm_rd_data_i),
        .valid_o   (valid_o),
        .data_o    (pxl_o)
    );

endmodule

// File: tb/tb_conv_3x3_stream_feeder.sv
module tb_conv_3x3_stream_feeder;

    localparam int unsigned Dw = 32;
    // Small instance: 4x4 planes, 2 in, 2 out channels.
    localparam int unsigned SmFmAw = 5;   // clog2(2*16)
    localparam int unsigned SmWtAw = 6;   // clog2(2*2*9)
    // Default instance: 16x16, 256 x 256.
    localparam int unsigned DfFmAw = 16;  // clog2(256*256)
    localparam int unsigned DfWtAw = 20;  // clog2(256*256*9)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic start_df = 1'b0;

    logic              fm_rd_en, wt_rd_en, valid, valid_wt, busy, done;
    logic [SmFmAw-1:0] fm_rd_addr;
    logic [SmWtAw-1:0] wt_rd_addr;
    logic [Dw-1:0]     fm_rd_data = '0, wt_rd_data = '0, pxl, weight;

    logic              df_fm_rd_en, df_wt_rd_en, df_valid, df_valid_wt, df_busy, df_done;
    logic [DfFmAw-1:0] df_fm_rd_addr;
    logic [DfWtAw-1:0] df_wt_rd_addr;
    logic [Dw-1:0]     df_fm_rd_data = '0, df_wt_rd_data = '0, df_pxl, df_weight;

    always #5 clk = ~clk;

    // RAM models: data = address, one-cycle read latency.
    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= Dw'(fm_rd_addr);
        if (wt_rd_en) wt_rd_data <= Dw'(wt_rd_addr);
        if (df_fm_rd_en) df_fm_rd_data <= Dw'(df_fm_rd_addr);
        if (df_wt_rd_en) df_wt_rd_data <= Dw'(df_wt_rd_addr);
    end

    conv_3x3_stream_feeder #(
        .DATA_WIDTH(Dw), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold),
        .fm_rd_en_o(fm_rd_en), .fm_rd_addr_o(fm_rd_addr), .fm_rd_data_i(fm_rd_data),
        .wt_rd_en_o(wt_rd_en), .wt_rd_addr_o(wt_rd_addr), .wt_rd_data_i(wt_rd_data),
        .pxl_o(pxl), .valid_o(valid), .weight_o(weight), .valid_weight_o(valid_wt),
        .busy_o(busy), .done_o(done)
    );

    conv_3x3_stream_feeder dut_df (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_df), .hold_i(1'b0),
        .fm_rd_en_o(df_fm_rd_en), .fm_rd_addr_o(df_fm_rd_addr), .fm_rd_data_i(df_fm_rd_data),
        .wt_rd_en_o(df_wt_rd_en), .wt_rd_addr_o(df_wt_rd_addr), .wt_rd_data_i(df_wt_rd_data),
        .pxl_o(df_pxl), .valid_o(df_valid), .weight_o(df_weight), .valid_weight_o(df_valid_wt),
        .busy_o(df_busy), .done_o(df_done)
    );

    typedef struct {
        logic        is_wt;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        string name;
        int    hold_at;
        int    hold_len;
        int    spur;
        int    exp_valids;
        int    exp_done;
        int    exp_first_wv;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   nchecks = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference stream order for the 2x2-channel, 4x4 layer.
    task automatic push_layer();
        exp_t e;
        for (int co = 0; co < 2; co++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int k = 0; k < 9; k++) begin
                    e.is_wt = 1'b1;
                    e.val   = 32'((co * 2 + ci) * 9 + k);
                    sb_q.push_back(e);
                end
                for (int p = 0; p < 16; p++) begin
                    e.is_wt = 1'b0;
                    e.val   = 32'(ci * 16 + p);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic pop_check(input string name, input logic is_wt, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, "_unexpected"}, {is_wt, data}, 33'h1_ffff_ffff);
        end else begin
            e = sb_q.pop_front();
            check(name, {is_wt, data}, {e.is_wt, e.val});
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge that
    // ends the done cycle (i.e. in the cycle after done).
    task automatic run_vec(input vec_t v);
        int cyc = 1;
        int nvalid = 0;
        int done_cyc = 0;
        int first_wv = 0;
        int overlap = 0;
        int busy_low = 0;
        check({v.name, "_idle_busy"}, {32'd0, busy}, 33'd0);
        push_layer();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc <= 200 && done_cyc == 0) begin
            start = (v.spur != 0) && (cyc == 2 || cyc == 50 || cyc == v.exp_done);
            hold  = (cyc >= v.hold_at) && (cyc < v.hold_at + v.hold_len);
            @(negedge clk);
            if (cyc == 1) begin
                check({v.name, "_first_wt_rd"}, {26'd0, wt_rd_en, wt_rd_addr}, {26'd0, 1'b1, 6'd0});
            end
            if (wt_rd_en && fm_rd_en) overlap++;
            if (busy !== 1'b1) busy_low++;
            if (valid_wt) begin
                nvalid++;
                if (first_wv == 0) first_wv = cyc;
                pop_check({v.name, "_wt_stream"}, 1'b1, weight);
            end
            if (valid) begin
                nvalid++;
                pop_check({v.name, "_px_stream"}, 1'b0, pxl);
            end
            if (done) done_cyc = cyc;
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        hold  = 1'b0;
        check({v.name, "_done_cycle"}, 33'(done_cyc), 33'(v.exp_done));
        check({v.name, "_valid_count"}, 33'(nvalid), 33'(v.exp_valids));
        check({v.name, "_first_wt_valid"}, 33'(first_wv), 33'(v.exp_first_wv));
        check({v.name, "_rd_en_overlap"}, 33'(overlap), 33'd0);
        check({v.name, "_busy_gaps"}, 33'(busy_low), 33'd0);
        check({v.name, "_sb_left"}, 33'(sb_q.size()), 33'd0);
        check({v.name, "_busy_after_done"}, {32'd0, busy}, 33'd0);
    endtask

    initial begin
        int seen;
        int nwv;
        int npx;
        vecs[0] = '{"plain", 0, 0, 0, 100, 103, 3};
        vecs[1] = '{"hold_mid", 15, 5, 0, 100, 108, 3};
        vecs[2] = '{"hold_wt2px", 84, 3, 0, 100, 106, 3};
        vecs[3] = '{"spur_start", 0, 0, 1, 100, 103, 3};
        vecs[4] = '{"second_layer", 0, 0, 0, 100, 103, 3};

        repeat (3) @(posedge clk);
        #1 check("reset_outputs",
                 {4'd0, busy, done, valid, valid_wt, fm_rd_en, wt_rd_en, pxl[10:0], weight[11:0]},
                 33'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back layers: each starts in the cycle after the previous done.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort mid-layer with reset.
        push_layer();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_outputs",
                 {21'd0, busy, done, valid, valid_wt, fm_rd_en, wt_rd_en, pxl[2:0], weight[2:0]},
                 33'd0);
        check("abort_addrs", {22'd0, fm_rd_addr, wt_rd_addr}, 33'd0);
        check("abort_data", {1'b0, pxl | weight}, 33'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (done || valid || valid_wt || busy) seen++;
        end
        check("abort_no_activity", 33'(seen), 33'd0);
        @(posedge clk);
        #1 run_vec(vecs[0]);

        // Default-parameter smoke run: 9 weights, 256 pixels, then weight address 9.
        nwv = 0;
        npx = 0;
        start_df = 1'b1;
        @(posedge clk);
        #1 start_df = 1'b0;
        for (int cyc = 1; cyc <= 267; cyc++) begin
            @(negedge clk);
            if (df_valid_wt) begin
                check("df_weight", {1'b0, df_weight}, 33'(nwv));
                nwv++;
            end
            if (df_valid) begin
                check("df_pixel_after_wts", 33'(nwv), 33'd9);
                check("df_pixel", {1'b0, df_pxl}, 33'(npx));
                npx++;
            end
            if (cyc == 266) begin
                check("df_next_wt_rd", {12'd0, df_wt_rd_en, df_wt_rd_addr}, {12'd0, 1'b1, 20'd9});
            end
            @(posedge clk);
            #1;
        end
        check("df_weight_count", 33'(nwv), 33'd9);
        check("df_pixel_count", 33'(npx), 33'd256);
        check("df_busy", {32'd0, df_busy}, 33'd1);
        rst_n = 1'b0;
        #1 check("df_reset_busy", {32'd0, df_busy}, 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
